// File: rtl/sw_arb2_pkg.sv
// Shared definitions for the two-port switch arbiter: flit layout, type codes,
// select encodings and FSM state encoding.
// Imported by sw_arb2, rr_pick2 and the bench so that no width literal lives elsewhere.
package sw_arb2_pkg;

  // Flit is [DATAW:0]; the top two bits carry the flit type.
  localparam int DATAW = 33;
  // Select bus is [PORT:0], one bit per input port.
  localparam int PORT  = 1;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  localparam logic [PORT:0] SEL_NONE = (PORT+1)'(0);
  localparam logic [PORT:0] SEL_P0   = (PORT+1)'(1);
  localparam logic [PORT:0] SEL_P1   = (PORT+1)'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  function automatic logic [1:0] flit_type(input logic [DATAW:0] flit);
    return flit[DATAW -: 2];
  endfunction

endpackage

// File: rtl/sw_arb2_rr_pick2.sv
// Two-way round-robin pick: grants the single requester, or on a tie the port
// that was not granted last. Purely combinational (zero latency, no backpressure).
// Ports: req[1:0] requests, last = index of last-granted port, gnt one-hot grant.
module rr_pick2
  import sw_arb2_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sw_arb2.sv
// Two-port packet-locking switch arbiter driving the select of an external 2:1 flit mux.
// Latency: HEAD seen in cycle N gives sel from N+1; one IDLE bubble between packets.
// Backpressure: ordy=0 stalls transfers but keeps the lock; a silent locked port is
// released after TIMEOUT idle cycles with a one-cycle timeout pulse.
// Ports: clk, rst_ (async active-low); idata_x/ivalid_x input flits; ordy downstream
// ready; sel registered one-hot mux select; igrant_x transfer strobes; timeout pulse.
module sw_arb2
  import sw_arb2_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int RR_INIT = 1
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [DATAW:0] idata_0,
  input  logic           ivalid_0,
  input  logic [DATAW:0] idata_1,
  input  logic           ivalid_1,
  input  logic           ordy,
  output logic [PORT:0]  sel,
  output logic           igrant_0,
  output logic           igrant_1,
  output logic           timeout
);

  localparam int   CW      = $clog2(TIMEOUT) + 1;
  localparam logic RR_LAST = (RR_INIT != 0);

  state_t         state;
  logic           last;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [1:0]     req;
  logic [1:0]     pick;
  logic           cur_port;
  logic           cur_vld;
  logic           cur_grant;
  logic           cur_tail;
  logic           expire;
  logic           unused_payload;

  assign igrant_0 = (state == LOCK0) & ivalid_0 & ordy;
  assign igrant_1 = (state == LOCK1) & ivalid_1 & ordy;

  // Only a valid HEAD opens a packet.
  assign req[0] = ivalid_0 & (flit_type(idata_0) == TYPE_HEAD);
  assign req[1] = ivalid_1 & (flit_type(idata_1) == TYPE_HEAD);

  rr_pick2 u_pick (
    .req  (req),
    .last (last),
    .gnt  (pick)
  );

  assign cur_port  = (state == LOCK1);
  assign cur_vld   = cur_port ? ivalid_1 : ivalid_0;
  assign cur_grant = igrant_0 | igrant_1;
  assign cur_tail  = flit_type(cur_port ? idata_1 : idata_0) == TYPE_TAIL;

  // Saturating increment; the counter never wraps back to zero.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

  // Fires in the cycle the idle count reaches TIMEOUT-1, so the registered pulse
  // and the release land TIMEOUT cycles after the last transfer. A valid flit
  // (including a TAIL being transferred) blocks it, so TAIL always wins a tie.
  assign expire = (state != IDLE) && !cur_vld && (cnt_inc >= CW'(TIMEOUT - 1));

  assign unused_payload = ^{idata_0[DATAW-2:0], idata_1[DATAW-2:0]};

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      sel     <= SEL_NONE;
      cnt     <= '0;
      timeout <= 1'b0;
      last    <= RR_LAST;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick[0]) begin
            state <= LOCK0;
            sel   <= SEL_P0;
          end else if (pick[1]) begin
            state <= LOCK1;
            sel   <= SEL_P1;
          end
        end
        LOCK0, LOCK1: begin
          if (cur_grant && cur_tail) begin
            state <= IDLE;
            sel   <= SEL_NONE;
            last  <= cur_port;
            cnt   <= '0;
          end else if (expire) begin
            state   <= IDLE;
            sel     <= SEL_NONE;
            last    <= cur_port;
            cnt     <= '0;
            timeout <= 1'b1;
          end else if (cur_grant) begin
            cnt <= '0;
          end else if (!cur_vld) begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= SEL_NONE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
